// File: rtl/rx_serial_7o1_if.sv
// Signal bundle between the serial receiver and its consumer.
// The receiver takes the slave modport; the line driver / consumer takes master.
interface rx_serial_7o1_if;
    logic       dado_serial;
    logic       limpa;
    logic [6:0] dados_ascii;
    logic       pronto;
    logic       tem_dado;
    logic       erro_paridade;
    logic       erro_frame;
    logic [3:0] db_estado;

    modport slave (
        input  dado_serial,
        input  limpa,
        output dados_ascii,
        output pronto,
        output tem_dado,
        output erro_paridade,
        output erro_frame,
        output db_estado
    );

    modport master (
        output dado_serial,
        output limpa,
        input  dados_ascii,
        input  pronto,
        input  tem_dado,
        input  erro_paridade,
        input  erro_frame,
        input  db_estado
    );
endinterface

// File: rtl/rx_serial_7o1.sv
// UART receiver, 7 data bits LSB first, odd parity, 1 stop bit, idle high.
// Samples mid-bit, reports parity/framing errors and a sticky tem_dado flag.
module rx_serial_7o1 #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input logic            clock,
    input logic            reset,
    rx_serial_7o1_if.slave bus
);
    localparam int unsigned   TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TICK_BIT  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        START       = 4'd1,
        DADOS       = 4'd2,
        PARIDADE    = 4'd3,
        STOP        = 4'd4,
        FINAL       = 4'd5,
        ESPERA_IDLE = 4'd6
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          sync1;
    logic          rx_s;
    logic          rx_prev;
    logic          fall;
    logic [TW-1:0] tick;
    logic [2:0]    bitcnt;
    logic [6:0]    shift;
    logic          par_bit;
    logic [6:0]    dados;
    logic          pronto;
    logic          tem_dado;
    logic          erro_p;
    logic          erro_f;

    logic          counting;
    logic          tick_clr;
    logic          bit_clr;
    logic          shift_en;
    logic          par_en;
    logic          stop_en;

    assign fall = rx_prev & ~rx_s;

    // Two-flop synchroniser on the RX line plus previous-sample flop for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= bus.dado_serial;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INICIAL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_next = state;
        counting   = 1'b0;
        tick_clr   = 1'b0;
        bit_clr    = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        stop_en    = 1'b0;
        case (state)
            INICIAL: begin
                if (fall) begin
                    tick_clr   = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                counting = 1'b1;
                if (tick == TICK_HALF) begin
                    tick_clr = 1'b1;
                    if (!rx_s) begin
                        bit_clr    = 1'b1;
                        state_next = DADOS;
                    end else begin
                        state_next = INICIAL;
                    end
                end
            end
            DADOS: begin
                counting = 1'b1;
                if (tick == TICK_BIT) begin
                    tick_clr = 1'b1;
                    shift_en = 1'b1;
                    if (bitcnt == 3'd6) begin
                        state_next = PARIDADE;
                    end
                end
            end
            PARIDADE: begin
                counting = 1'b1;
                if (tick == TICK_BIT) begin
                    tick_clr   = 1'b1;
                    par_en     = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                counting = 1'b1;
                if (tick == TICK_BIT) begin
                    tick_clr   = 1'b1;
                    stop_en    = 1'b1;
                    state_next = FINAL;
                end
            end
            FINAL: begin
                // erro_frame was loaded on the stop sample, so it is valid here.
                state_next = erro_f ? ESPERA_IDLE : INICIAL;
            end
            ESPERA_IDLE: begin
                if (rx_s) begin
                    state_next = INICIAL;
                end
            end
            default: state_next = INICIAL;
        endcase
    end

    // Tick/bit counters, shift register and result registers.
    // Results are loaded on the stop sample so they are already valid while pronto is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick     <= '0;
            bitcnt   <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            dados    <= '0;
            pronto   <= 1'b0;
            tem_dado <= 1'b0;
            erro_p   <= 1'b0;
            erro_f   <= 1'b0;
        end else begin
            if (tick_clr || !counting) begin
                tick <= '0;
            end else begin
                tick <= tick + TW'(1);
            end
            if (bit_clr) begin
                bitcnt <= '0;
            end else if (shift_en) begin
                bitcnt <= bitcnt + 3'd1;
            end
            if (shift_en) begin
                shift <= {rx_s, shift[6:1]};
            end
            if (par_en) begin
                par_bit <= rx_s;
            end
            pronto <= stop_en;
            if (stop_en) begin
                dados  <= shift;
                erro_p <= ~(^{shift, par_bit});
                erro_f <= ~rx_s;
            end
            // Set during FINAL takes priority over a simultaneous limpa.
            if (state == FINAL) begin
                tem_dado <= 1'b1;
            end else if (bus.limpa) begin
                tem_dado <= 1'b0;
            end
        end
    end

    assign bus.dados_ascii   = dados;
    assign bus.pronto        = pronto;
    assign bus.tem_dado      = tem_dado;
    assign bus.erro_paridade = erro_p;
    assign bus.erro_frame    = erro_f;
    assign bus.db_estado     = state;
endmodule

// File: tb/tb_rx_serial_7o1.sv
// Testbench for rx_serial_7o1 with CLKS_PER_BIT = 8.
// Frames are pushed to a scoreboard when driven and checked when pronto fires.
module tb_rx_serial_7o1;
    localparam int unsigned CPB = 8;

    typedef struct {
        logic [6:0] data;
        logic       ep;
        logic       ef;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pronto_cnt = 0;

    rx_serial_7o1_if bus ();

    rx_serial_7o1 #(.CLKS_PER_BIT(CPB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Scoreboard monitor: every pronto pulse pops one expected frame.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus.pronto === 1'b1) begin
            pronto_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_pronto: got pronto with %0d frames pending, required pending frame", sb.size());
            end else begin
                e = sb.pop_front();
                checks++;
                if (bus.dados_ascii !== e.data) begin
                    errors++;
                    $display("FAIL sb_data: got %h required %h", bus.dados_ascii, e.data);
                end
                checks++;
                if (bus.erro_paridade !== e.ep) begin
                    errors++;
                    $display("FAIL sb_erro_paridade: got %b required %b", bus.erro_paridade, e.ep);
                end
                checks++;
                if (bus.erro_frame !== e.ef) begin
                    errors++;
                    $display("FAIL sb_erro_frame: got %b required %b", bus.erro_frame, e.ef);
                end
            end
        end
    end

    task automatic send_frame(input logic [6:0] d, input logic par, input logic stp, input int idle_bits);
        logic [9:0] f;
        f = {stp, par, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.dado_serial = f[i];
            repeat (CPB) @(negedge clock);
        end
        bus.dado_serial = 1'b1;
        repeat (idle_bits * int'(CPB)) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.dado_serial = 1'b1;
        bus.limpa = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (20 * CPB) @(negedge clock);
        checks++;
        if (bus.dados_ascii !== 7'h00) begin errors++; $display("FAIL reset_data: got %h required 00", bus.dados_ascii); end
        checks++;
        if (bus.pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto: got %b required 0", bus.pronto); end
        checks++;
        if (bus.tem_dado !== 1'b0) begin errors++; $display("FAIL reset_tem_dado: got %b required 0", bus.tem_dado); end
        checks++;
        if (bus.erro_paridade !== 1'b0) begin errors++; $display("FAIL reset_erro_paridade: got %b required 0", bus.erro_paridade); end
        checks++;
        if (bus.erro_frame !== 1'b0) begin errors++; $display("FAIL reset_erro_frame: got %b required 0", bus.erro_frame); end
        checks++;
        if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado: got %0d required 0", bus.db_estado); end
        checks++;
        if (pronto_cnt !== 0) begin errors++; $display("FAIL reset_no_pronto: got %0d pulses required 0", pronto_cnt); end
    endtask

    task automatic test_basic();
        int p0;
        p0 = pronto_cnt;
        sb.push_back('{7'h41, 1'b0, 1'b0});
        send_frame(7'h41, 1'b1, 1'b1, 2);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL basic_drain: got %0d pending required 0", sb.size()); end
        checks++;
        if (pronto_cnt - p0 != 1) begin errors++; $display("FAIL basic_pronto_count: got %0d required 1", pronto_cnt - p0); end
        checks++;
        if (bus.dados_ascii !== 7'h41) begin errors++; $display("FAIL basic_data_hold: got %h required 41", bus.dados_ascii); end
        checks++;
        if (bus.tem_dado !== 1'b1) begin errors++; $display("FAIL basic_tem_dado: got %b required 1", bus.tem_dado); end
        bus.limpa = 1'b1;
        @(negedge clock);
        bus.limpa = 1'b0;
        checks++;
        if (bus.tem_dado !== 1'b0) begin errors++; $display("FAIL basic_limpa: got %b required 0", bus.tem_dado); end
    endtask

    task automatic test_errors_b2b();
        int p0;
        p0 = pronto_cnt;
        sb.push_back('{7'h43, 1'b1, 1'b0});
        sb.push_back('{7'h35, 1'b0, 1'b0});
        send_frame(7'h43, 1'b1, 1'b1, 0);
        send_frame(7'h35, 1'b1, 1'b1, 2);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending required 0", sb.size()); end
        checks++;
        if (pronto_cnt - p0 != 2) begin errors++; $display("FAIL b2b_pronto_count: got %0d required 2", pronto_cnt - p0); end
        checks++;
        if (bus.dados_ascii !== 7'h35) begin errors++; $display("FAIL b2b_data: got %h required 35", bus.dados_ascii); end
        checks++;
        if (bus.erro_paridade !== 1'b0) begin errors++; $display("FAIL b2b_erro_paridade: got %b required 0", bus.erro_paridade); end
    endtask

    task automatic test_glitch();
        int   p0;
        logic saw_start;
        p0 = pronto_cnt;
        saw_start = 1'b0;
        bus.dado_serial = 1'b0;
        repeat (2) @(negedge clock);
        bus.dado_serial = 1'b1;
        for (int i = 0; i < 3 * int'(CPB); i++) begin
            @(negedge clock);
            if (bus.db_estado === 4'd1) saw_start = 1'b1;
        end
        checks++;
        if (saw_start !== 1'b1) begin errors++; $display("FAIL glitch_start_seen: got %b required 1", saw_start); end
        checks++;
        if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL glitch_estado: got %0d required 0", bus.db_estado); end
        checks++;
        if (pronto_cnt - p0 != 0) begin errors++; $display("FAIL glitch_no_pronto: got %0d required 0", pronto_cnt - p0); end
        checks++;
        if (bus.dados_ascii !== 7'h35) begin errors++; $display("FAIL glitch_data: got %h required 35", bus.dados_ascii); end
        checks++;
        if (bus.tem_dado !== 1'b1) begin errors++; $display("FAIL glitch_tem_dado: got %b required 1", bus.tem_dado); end
    endtask

    task automatic test_break();
        int p0;
        p0 = pronto_cnt;
        sb.push_back('{7'h41, 1'b0, 1'b1});
        send_frame(7'h41, 1'b1, 1'b0, 0);
        bus.dado_serial = 1'b0;
        repeat (3 * CPB) @(negedge clock);
        checks++;
        if (bus.db_estado !== 4'd6) begin errors++; $display("FAIL break_estado: got %0d required 6", bus.db_estado); end
        checks++;
        if (bus.erro_frame !== 1'b1) begin errors++; $display("FAIL break_erro_frame: got %b required 1", bus.erro_frame); end
        checks++;
        if (pronto_cnt - p0 != 1) begin errors++; $display("FAIL break_pronto_count: got %0d required 1", pronto_cnt - p0); end
        bus.dado_serial = 1'b1;
        repeat (CPB) @(negedge clock);
        checks++;
        if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL break_idle_estado: got %0d required 0", bus.db_estado); end
        checks++;
        if (pronto_cnt - p0 != 1) begin errors++; $display("FAIL break_no_second_pronto: got %0d required 1", pronto_cnt - p0); end
        sb.push_back('{7'h41, 1'b0, 1'b0});
        send_frame(7'h41, 1'b1, 1'b1, 2);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL break_drain: got %0d pending required 0", sb.size()); end
        checks++;
        if (bus.erro_frame !== 1'b0) begin errors++; $display("FAIL break_recover_erro_frame: got %b required 0", bus.erro_frame); end
    endtask

    task automatic test_reset_mid();
        int         p0;
        logic [9:0] f;
        f = {1'b1, 1'b1, 7'h41, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.dado_serial = f[i];
            repeat (CPB) @(negedge clock);
        end
        bus.dado_serial = f[5];
        repeat (4) @(negedge clock);
        checks++;
        if (bus.db_estado !== 4'd2) begin errors++; $display("FAIL midrst_in_dados: got %0d required 2", bus.db_estado); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.dados_ascii !== 7'h00) begin errors++; $display("FAIL midrst_data: got %h required 00", bus.dados_ascii); end
        checks++;
        if (bus.tem_dado !== 1'b0) begin errors++; $display("FAIL midrst_tem_dado: got %b required 0", bus.tem_dado); end
        checks++;
        if (bus.erro_frame !== 1'b0) begin errors++; $display("FAIL midrst_erro_frame: got %b required 0", bus.erro_frame); end
        checks++;
        if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL midrst_estado: got %0d required 0", bus.db_estado); end
        repeat (2) @(negedge clock);
        bus.dado_serial = 1'b1;
        reset = 1'b0;
        p0 = pronto_cnt;
        repeat (2 * CPB) @(negedge clock);
        checks++;
        if (pronto_cnt - p0 != 0) begin errors++; $display("FAIL midrst_no_pronto: got %0d required 0", pronto_cnt - p0); end
        sb.push_back('{7'h35, 1'b0, 1'b0});
        send_frame(7'h35, 1'b1, 1'b1, 2);
        checks++;
        if (pronto_cnt - p0 != 1) begin errors++; $display("FAIL midrst_next_pronto: got %0d required 1", pronto_cnt - p0); end
        checks++;
        if (bus.dados_ascii !== 7'h35) begin errors++; $display("FAIL midrst_next_data: got %h required 35", bus.dados_ascii); end
    endtask

    task automatic test_limpa_same();
        logic hit;
        bus.limpa = 1'b1;
        @(negedge clock);
        bus.limpa = 1'b0;
        checks++;
        if (bus.tem_dado !== 1'b0) begin errors++; $display("FAIL same_pre_clear: got %b required 0", bus.tem_dado); end
        hit = 1'b0;
        sb.push_back('{7'h41, 1'b0, 1'b0});
        fork
            send_frame(7'h41, 1'b1, 1'b1, 2);
            begin
                for (int i = 0; i < 12 * int'(CPB) && !hit; i++) begin
                    @(negedge clock);
                    if (bus.pronto === 1'b1) begin
                        hit = 1'b1;
                        bus.limpa = 1'b1;
                    end
                end
                @(negedge clock);
                bus.limpa = 1'b0;
            end
        join
        checks++;
        if (hit !== 1'b1) begin errors++; $display("FAIL same_pronto_timeout: got %b required 1", hit); end
        checks++;
        if (bus.tem_dado !== 1'b1) begin errors++; $display("FAIL same_set_wins: got %b required 1", bus.tem_dado); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL same_drain: got %0d pending required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors_b2b();
        test_glitch();
        test_break();
        test_reset_mid();
        test_limpa_same();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rx_serial_7o1.md
Name: rx_serial_7O1

Overview:
- UART receiver, the counterpart of the existing tx_serial_7O1 transmitter.
- Frame format: 1 start bit (0), 7 data bits LSB first, odd parity, 1 stop bit (1). Idle line is 1.
- Deserialises the asynchronous line into a 7-bit ASCII character and raises a one-cycle pronto pulse when the frame ends.
- Flags parity and framing errors, and holds a tem_dado flag until the consumer clears it.
- Sits in the sensor/serial datapath to accept commands from a PC or a peer board.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); minimum legal value 4.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- dado_serial  input  1  asynchronous RX line; idle high.
- limpa  input  1  one-cycle pulse; clears tem_dado.
- dados_ascii  output  7  last received character, bit 0 = first data bit on the line.
- pronto  output  1  one-cycle pulse at the end of every frame, whether the frame is good or bad.
- tem_dado  output  1  set at pronto; held until limpa.
- erro_paridade  output  1  parity check result of the last frame.
- erro_frame  output  1  stop-bit check result of the last frame.
- db_estado  output  4  current FSM state code.

Behaviour:
- Reset (async, active-high) forces the following values:
  - FSM to INICIAL;
  - dados_ascii = 0;
  - pronto, tem_dado, erro_paridade, erro_frame = 0;
  - bit and tick counters = 0;
  - both synchroniser flops = 1.
- Reset mid-frame aborts the frame. No pronto is produced for the aborted frame.
- Input synchronisation:
  - dado_serial passes through a 2-flop synchroniser; call its output rx_s.
  - A falling edge is rx_s = 0 while the previous rx_s = 1.
- FSM states and db_estado codes:
  - INICIAL = 0: wait for a falling edge on rx_s; on the edge, load the tick counter and go to START.
  - START = 1: count CLKS_PER_BIT/2 (integer division) cycles, then sample rx_s.
    - Sample = 0: clear the bit counter, go to DADOS.
    - Sample = 1: false start; return to INICIAL with no outputs changed.
  - DADOS = 2: every CLKS_PER_BIT cycles, sample rx_s into a shift register, LSB first. After the 7th sample, go to PARIDADE.
  - PARIDADE = 3: after CLKS_PER_BIT cycles, sample the parity bit, then go to STOP.
  - STOP = 4: after CLKS_PER_BIT cycles, sample the stop bit, then go to FINAL.
  - FINAL = 5: for one cycle:
    - pronto = 1;
    - update dados_ascii;
    - erro_paridade = 1 when XOR of the 7 data bits and the parity bit is 0 (even count of ones);
    - erro_frame = 1 when the stop sample was 0;
    - tem_dado <= 1;
    - go to INICIAL (or ESPERA_IDLE; see below).
  - ESPERA_IDLE = 6: entered only from FINAL when erro_frame = 1. Stay until rx_s = 1, then go to INICIAL. This prevents a break or stuck-low line from re-triggering a frame.
- Data-path rules:
  - dados_ascii and both error flags update on every completed frame, including erroneous ones.
  - Between frames, dados_ascii and both error flags hold their values.
- Timing:
  - Sampling is mid-bit. Sample n (n = 0 for start) occurs CLKS_PER_BIT/2 + n*CLKS_PER_BIT cycles after the edge is detected on rx_s.
  - pronto rises 1 cycle after the stop sample.
  - Total latency from the line falling edge to pronto: 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, ±1.
- limpa / tem_dado interaction:
  - limpa clears tem_dado on the next edge.
  - limpa in the same cycle as pronto: set wins, so tem_dado = 1.
- Overrun: a new frame arriving while tem_dado = 1 overwrites dados_ascii silently. tem_dado stays 1.
- A falling edge seen outside INICIAL is ignored.
- Back-to-back frames must be accepted: a start bit immediately after the stop bit, with zero idle time.

Test Plan:
- Reset release, line idle high for 20 bit-times -> all outputs 0, db_estado = 0, no pronto pulse.
- Send 'A' (0x41, parity = 1, stop = 1) with CLKS_PER_BIT = 8 -> exactly one pronto pulse; dados_ascii = 7'h41; tem_dado = 1; erro_paridade = 0; erro_frame = 0. Then pulse limpa -> tem_dado = 0.
- Send 'C' (0x43) with a wrong parity bit of 1 -> dados_ascii = 7'h43, erro_paridade = 1, erro_frame = 0. Then send '5' (0x35, parity = 1) back-to-back -> dados_ascii = 7'h35, both error flags 0, two pronto pulses total.
- Glitch low for 2 cycles (less than CLKS_PER_BIT/2) -> START samples 1, FSM returns to state 0, no pronto, outputs unchanged.
- Frame with stop bit = 0 and the line held low for 3 more bit-times -> erro_frame = 1 and pronto once. FSM sits in state 6 until the line goes high, with no second pronto. A following valid 'A' is then received correctly.
- Assert reset during DADOS (bit 4 of 'A') -> outputs cleared immediately. After release, the next full frame '5' is received with dados_ascii = 7'h35. Separately, drive limpa in the same cycle as pronto -> tem_dado = 1.
